// File: rtl/sdf_stage_8.sv
// -----------------------------------------------------------------------------
// sdf_stage_8 -- one radix-2 single-path delay-feedback (SDF) FFT stage with an
// 8-entry complex delay line.
//
// Each frame the stage runs through four phases, which the twiddle ROM drives
// on the state input:
//   0 fill      : the valid input sample is pushed into the delay line.
//   1 butterfly : head + din goes to the output, and head - din is pushed back.
//   2 twiddle   : head * w goes to the output, and din is pushed. These pushes
//                 are the fill of the next frame, so frames run back to back.
//   3 idle      : the delay line and the output hold.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          synchronous reset, ACTIVE-HIGH despite its name
//   in_valid       din_r/din_i carry a valid sample (used in fill only)
//   din_r, din_i   signed 24-bit sample, 8 fractional bits
//   state          stage phase: 0 fill, 1 butterfly, 2 twiddle, 3 idle
//   w_r, w_i       signed 24-bit twiddle factor, 8 fractional bits
//   out_valid      dout_r/dout_i hold a new result (registered)
//   dout_r, dout_i signed 24-bit result, 8 fractional bits (registered)
//
// Configuration
//   SDF_ROUND_EN   when defined, the twiddle products are rounded half up
//                  before the >>8 rescale. When it is not defined, they are
//                  truncated toward -inf. This choice has no effect on the
//                  butterfly path.
// -----------------------------------------------------------------------------
module sdf_stage_8 (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic signed [23:0] din_r,
    input  logic signed [23:0] din_i,
    input  logic        [1:0]  state,
    input  logic signed [23:0] w_r,
    input  logic signed [23:0] w_i,
    output logic               out_valid,
    output logic signed [23:0] dout_r,
    output logic signed [23:0] dout_i
);

    localparam int DEPTH = 8;
    localparam int FRAC  = 8;

`ifdef SDF_ROUND_EN
    localparam logic signed [48:0] ROUND_BIAS = 49'sd128;
`else
    localparam logic signed [48:0] ROUND_BIAS = 49'sd0;
`endif

    typedef enum logic [1:0] {
        PH_FILL = 2'd0,
        PH_BFLY = 2'd1,
        PH_TWID = 2'd2,
        PH_IDLE = 2'd3
    } phase_t;

    typedef struct packed {
        logic signed [23:0] re;
        logic signed [23:0] im;
    } cplx_t;

    phase_t phase;
    assign phase = phase_t'(state);

    // Entry 0 is the head (oldest). New samples enter at entry DEPTH-1.
    cplx_t line_q [DEPTH];
    cplx_t line_d [DEPTH];
    cplx_t dout_q, dout_d;
    logic  out_valid_q, out_valid_d;

    cplx_t head;
    assign head = line_q[0];

    // Butterfly arithmetic is done at 25 bits and then wrapped to 24 bits.
    logic signed [24:0] sum_r, sum_i, diff_r, diff_i;

    // Complex product: 48-bit partial products and 49-bit real/imag sums.
    logic signed [47:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [48:0] acc_r, acc_i;
    logic signed [48:0] scl_r, scl_i;

    always_comb begin
        sum_r  = 25'(head.re) + 25'(din_r);
        sum_i  = 25'(head.im) + 25'(din_i);
        diff_r = 25'(head.re) - 25'(din_r);
        diff_i = 25'(head.im) - 25'(din_i);

        p_rr  = 48'(head.re) * 48'(w_r);
        p_ii  = 48'(head.im) * 48'(w_i);
        p_ri  = 48'(head.re) * 48'(w_i);
        p_ir  = 48'(head.im) * 48'(w_r);
        acc_r = 49'(p_rr) - 49'(p_ii) + ROUND_BIAS;
        acc_i = 49'(p_ri) + 49'(p_ir) + ROUND_BIAS;
        scl_r = acc_r >>> FRAC;
        scl_i = acc_i >>> FRAC;
    end

    logic  advance;
    cplx_t push_val;

    always_comb begin
        // NOTE: Every signal this block drives gets a default value first. This
        // keeps a phase that does not assign a signal from inferring a latch.
        advance     = 1'b0;
        push_val    = '0;
        dout_d      = dout_q;
        out_valid_d = 1'b0;

        unique case (phase)
            PH_FILL: begin
                advance  = in_valid;
                push_val = '{re: din_r, im: din_i};
            end
            PH_BFLY: begin
                advance     = 1'b1;
                push_val    = '{re: 24'(diff_r), im: 24'(diff_i)};
                dout_d      = '{re: 24'(sum_r), im: 24'(sum_i)};
                out_valid_d = 1'b1;
            end
            PH_TWID: begin
                advance     = 1'b1;
                push_val    = '{re: din_r, im: din_i};
                dout_d      = '{re: 24'(scl_r), im: 24'(scl_i)};
                out_valid_d = 1'b1;
            end
            PH_IDLE: begin
                advance = 1'b0;
            end
            default: begin
                advance = 1'b0;
            end
        endcase

        for (int k = 0; k < DEPTH; k++) begin
            line_d[k] = line_q[k];
        end
        if (advance) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                line_d[k] = line_q[k + 1];
            end
            line_d[DEPTH - 1] = push_val;
        end
    end

    // rst_n is active-high. A frame interrupted by reset restarts with an
    // empty (all-zero) delay line.
    always_ff @(posedge clk) begin
        // NOTE: Sequential state is assigned with <= only. Every flop then
        // samples its pre-edge value, which the shift chain depends on.
        if (rst_n) begin
            // NOTE: The delay line is cleared on reset even though it is a
            // memory. Stale samples from an aborted frame must not leak into
            // the next frame's butterflies.
            for (int k = 0; k < DEPTH; k++) begin
                line_q[k] <= '0;
            end
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                line_q[k] <= line_d[k];
            end
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout_r    = dout_q.re;
    assign dout_i    = dout_q.im;

endmodule

// File: tb/tb_sdf_stage_8.sv
// -----------------------------------------------------------------------------
// tb_sdf_stage_8 -- directed, self-checking bench for sdf_stage_8.
// A vector table drives the nominal multi-frame flow, which includes
// back-to-back frames and several twiddle values. Hand-written sequences then
// cover rounding, wrap-around, reset in the middle of a frame, and idle in the
// middle of a fill. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at that same point, which is away from the edge.
// -----------------------------------------------------------------------------
module tb_sdf_stage_8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [23:0] din_r, din_i, w_r, w_i;
    logic        [1:0]  state;
    logic               out_valid;
    logic signed [23:0] dout_r, dout_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdf_stage_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .state     (state),
        .w_r       (w_r),
        .w_i       (w_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    typedef struct {
        logic [1:0] st;
        logic       iv;
        int         dr, di, wr, wi;
        logic       ev;
        int         er, ei;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [1:0] st, input logic iv,
                                input int dr, input int di, input int wr, input int wi,
                                input logic ev, input int er, input int ei,
                                input string tag);
        vecs.push_back('{st: st, iv: iv, dr: dr, di: di, wr: wr, wi: wi,
                         ev: ev, er: er, ei: ei, tag: tag});
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, and check the registered outputs.
    task automatic step(input logic rst, input logic [1:0] st, input logic iv,
                        input int dr, input int di, input int wr, input int wi,
                        input logic ev, input int er, input int ei,
                        input string tag);
        rst_n    = rst;
        state    = st;
        in_valid = iv;
        din_r    = 24'(dr);
        din_i    = 24'(di);
        w_r      = 24'(wr);
        w_i      = 24'(wi);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".re"}, 32'(dout_r), ei == ei ? er : 0);
        check({tag, ".im"}, 32'(dout_i), ei);
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 2'd3, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0, tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        state    = 2'd3;
        in_valid = 1'b0;
        din_r    = '0;
        din_i    = '0;
        w_r      = '0;
        w_i      = '0;
        #1;

        // ---------------- table: nominal frames ----------------
        // Frame A: fill with 256, butterfly with din 256 (in_valid toggled).
        for (int k = 0; k < 8; k++) add(2'd0, 1'b1, 256, 0, 0, 0, 1'b0, 0, 0, "a_fill");
        for (int k = 0; k < 8; k++) add(2'd1, 1'(k), 256, 0, 0, 0, 1'b1, 512, 0, "a_bfly");
        // The butterfly pushed head - din = 0, so head*w is 0. Pushes din = 256.
        for (int k = 0; k < 8; k++) add(2'd2, 1'b1, 256, 0, 256, 0, 1'b1, 0, 0, "a_twid");
        add(2'd3, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0, "a_idle");
        // Frame B: the fill with 512 flushes the 256s. Butterfly din 0 keeps 512 in the line.
        for (int k = 0; k < 8; k++) add(2'd0, 1'b1, 512, 0, 0, 0, 1'b0, 0, 0, "b_fill");
        for (int k = 0; k < 8; k++) add(2'd1, 1'b0, 0, 0, 0, 0, 1'b1, 512, 0, "b_bfly");
        add(2'd2, 1'b1, 100, -50, 256, 0, 1'b1, 512, 0, "b_tw0");
        add(2'd2, 1'b1, 100, -50, 181, -181, 1'b1, 362, -362, "b_tw1");
        add(2'd2, 1'b1, 100, -50, 0, -256, 1'b1, 0, -512, "b_tw2");
        for (int k = 0; k < 5; k++) add(2'd2, 1'b1, 100, -50, 256, 0, 1'b1, 512, 0, "b_twn");
        // Frame C follows with no bubble. Its fill is frame B's twiddle pushes (100,-50).
        for (int k = 0; k < 8; k++) add(2'd1, 1'b0, 10, 20, 0, 0, 1'b1, 110, -30, "c_bfly");
        for (int k = 0; k < 2; k++) add(2'd2, 1'b1, 0, 0, 256, 0, 1'b1, 90, -70, "c_twid");
        add(2'd3, 1'b1, 7, 7, 0, 0, 1'b0, 90, -70, "c_idle_hold");
        add(2'd0, 1'b0, 7, 7, 0, 0, 1'b0, 90, -70, "c_fill_nv_hold");

        do_reset("reset");
        foreach (vecs[i]) begin
            step(1'b0, vecs[i].st, vecs[i].iv, vecs[i].dr, vecs[i].di,
                 vecs[i].wr, vecs[i].wi, vecs[i].ev, vecs[i].er, vecs[i].ei,
                 vecs[i].tag);
        end

        // ---------------- rounding: head (1,0), w (181,-181) ----------------
        do_reset("rnd_reset");
        step(1'b0, 2'd0, 1'b1, 1, 0, 0, 0, 1'b0, 0, 0, "rnd_fill");
        for (int k = 0; k < 7; k++) step(1'b0, 2'd0, 1'b1, 0, 0, 0, 0, 1'b0, 0, 0, "rnd_fill");
        step(1'b0, 2'd1, 1'b1, 0, 0, 0, 0, 1'b1, 1, 0, "rnd_bfly0");
        for (int k = 0; k < 7; k++) step(1'b0, 2'd1, 1'b1, 0, 0, 0, 0, 1'b1, 0, 0, "rnd_bfly");
`ifdef SDF_ROUND_EN
        step(1'b0, 2'd2, 1'b1, 0, 0, 181, -181, 1'b1, 1, -1, "rnd_twid");
`else
        step(1'b0, 2'd2, 1'b1, 0, 0, 181, -181, 1'b1, 0, -1, "rnd_twid");
`endif

        // ---------------- wrap: head max positive + 1 ----------------
        do_reset("wrap_reset");
        step(1'b0, 2'd0, 1'b1, 8388607, 0, 0, 0, 1'b0, 0, 0, "wrap_fill");
        for (int k = 0; k < 7; k++) step(1'b0, 2'd0, 1'b1, 0, 0, 0, 0, 1'b0, 0, 0, "wrap_fill");
        step(1'b0, 2'd1, 1'b1, 1, 0, 0, 0, 1'b1, -8388608, 0, "wrap_sum");
        for (int k = 0; k < 7; k++) step(1'b0, 2'd1, 1'b1, 0, 0, 0, 0, 1'b1, 0, 0, "wrap_bfly");
        step(1'b0, 2'd2, 1'b1, 0, 0, 256, 0, 1'b1, 8388606, 0, "wrap_diff");

        // ---------------- reset in the middle of a butterfly ----------------
        do_reset("mid_reset0");
        for (int k = 0; k < 8; k++) step(1'b0, 2'd0, 1'b1, 300, 5, 0, 0, 1'b0, 0, 0, "mid_fill");
        for (int k = 0; k < 3; k++) step(1'b0, 2'd1, 1'b1, 1, 1, 0, 0, 1'b1, 301, 6, "mid_bfly");
        step(1'b1, 2'd1, 1'b1, 1, 1, 0, 0, 1'b0, 0, 0, "mid_rst");
        for (int k = 0; k < 2; k++) step(1'b0, 2'd1, 1'b1, 7, 3, 0, 0, 1'b1, 7, 3, "mid_empty");

        // ---------------- idle and in_valid=0 in the middle of a fill ----------------
        do_reset("gap_reset");
        step(1'b0, 2'd0, 1'b1, 10, 1, 0, 0, 1'b0, 0, 0, "gap_fill");
        step(1'b0, 2'd0, 1'b1, 20, 2, 0, 0, 1'b0, 0, 0, "gap_fill");
        step(1'b0, 2'd0, 1'b0, 999, 9, 0, 0, 1'b0, 0, 0, "gap_novalid");
        step(1'b0, 2'd0, 1'b1, 30, 3, 0, 0, 1'b0, 0, 0, "gap_fill");
        step(1'b0, 2'd0, 1'b1, 40, 4, 0, 0, 1'b0, 0, 0, "gap_fill");
        for (int k = 0; k < 5; k++) step(1'b0, 2'd3, 1'b1, 555, 5, 0, 0, 1'b0, 0, 0, "gap_idle");
        for (int k = 5; k <= 8; k++) step(1'b0, 2'd0, 1'b1, 10 * k, k, 0, 0, 1'b0, 0, 0, "gap_fill");
        for (int k = 1; k <= 8; k++) step(1'b0, 2'd1, 1'b0, 0, 0, 0, 0, 1'b1, 10 * k, k, "gap_bfly");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: the stimulus above is finite, so this bound is never reached
    // unless the simulation stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdf_stage_8.md
SDF_STAGE_8 -- requirements
Module: sdf_stage_8

Interface
REQ-001: Ports SHALL be as follows; clock and reset first. Reset is one clock, synchronous, active-high.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  synchronous reset, active-high (asserted = 1), sampled on clk rising edge.
REQ-004: in_valid  input  1  din_r/din_i carry a valid sample this cycle.
REQ-005: din_r, din_i  input  24 each  signed two's-complement sample, 8 fractional bits (256 = 1.0).
REQ-006: state  input  2  stage phase from twiddle ROM: 0 fill, 1 butterfly, 2 twiddle, 3 idle.
REQ-007: w_r, w_i  input  24 each  signed twiddle factor, 8 fractional bits, valid in state 2.
REQ-008: out_valid  output  1  dout_r/dout_i valid this cycle.
REQ-009: dout_r, dout_i  output  24 each  signed result, 8 fractional bits, registered.

Function
REQ-010: Block SHALL hold an 8-entry complex delay line (24+24 bits/entry); head = oldest entry.
REQ-011: Advance (push tail, pop head) SHALL occur only in the cycles defined by REQ-012..REQ-015; all other cycles leave it unchanged.
REQ-012: state 0 and in_valid=1: push din; out_valid next cycle = 0. state 0 and in_valid=0: no advance, out_valid = 0.
REQ-013: state 1: a = head, b = din; register dout = a+b; push a-b; out_valid next cycle = 1. Push and output are independent of in_valid.
REQ-014: state 2: register dout = head*w (complex): re = hr*wr - hi*wi, im = hr*wi + hi*wr; push din; out_valid next cycle = 1.
REQ-015: state 3: no advance; out_valid next cycle = 0; dout holds its previous value.
REQ-016: Sum/diff SHALL be computed at 25 bits and wrapped to 24 bits (drop MSB, no saturation).
REQ-017: Products SHALL be full 48-bit signed; each real/imag sum at 49 bits; scale by arithmetic shift right 8; wrap to 24 bits.
REQ-018: Latency SHALL be exactly 1 cycle from the sampling edge to the registered dout/out_valid.
REQ-019: dout SHALL hold its last value whenever out_valid = 0.
REQ-020: Back-to-back frames SHALL work with no bubble: state 2 pushes of frame N are the fill of frame N+1; a state 2 -> state 1 transition SHALL need no extra cycle.

Reset
REQ-021: With rst_n = 1 at a clock edge, all delay-line entries, dout_r, dout_i and out_valid SHALL be 0 after that edge.
REQ-022: Reset SHALL override every state, including mid-frame. The first post-reset cycle SHALL behave as an empty delay line (entries = 0).

Configuration
REQ-023: Macro SDF_ROUND_EN, when defined, SHALL add 128 to each 49-bit product sum before the shift by 8 (round half up).
REQ-024: Without SDF_ROUND_EN, the shift SHALL truncate toward negative infinity. Butterfly paths are unaffected either way.

Verification
REQ-025: Reset then 8x state0 din=(256,0), 8x state1 din=(256,0), 8x state2 w=(256,0) -> state1 outputs (512,0) x8; state2 outputs (0,0) x8.
REQ-026: Fill with (512,0), state1 din=(0,0), state2 with w=(256,0),(181,-181),(0,-256) -> outputs (512,0),(362,-362),(0,-512).
REQ-027: Head=(1,0), w=(181,-181) -> without SDF_ROUND_EN dout=(0,-1); with SDF_ROUND_EN dout=(1,-1).
REQ-028: Head=(8388607,0), din=(1,0) in state1 -> dout_r = -8388608 (wrap); diff pushed = 8388606.
REQ-029: rst_n asserted on 4th state1 cycle -> next cycle out_valid=0, dout=(0,0); a subsequent frame's state1 outputs equal din (empty line).
REQ-030: state=3 for 5 cycles mid-fill, then fill resumes -> out_valid=0 throughout; later state1 results unchanged versus an uninterrupted run.
